// File: rtl/axi_ar_xbar.sv
// axi_ar_xbar
//   AXI read-address crossbar: NM masters -> NS slaves. The last slave
//   (NS-1) is the default / decode-error slave. Each cycle one requesting
//   master is selected (round-robin by default). Its ARADDR is decoded against
//   a base/mask map. The request is captured in a one-entry output slice that
//   drives exactly one slave. The master index is prepended to ARID.
//
//   Optional build macro: AXI_AR_XBAR_FIXED_PRIO_EN
//     defined   -> fixed priority, the lowest-index valid master always wins
//                  (no rotating pointer is built)
//     undefined -> round-robin arbitration (default)
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   asynchronous active-low reset
//   m_arid     in   NM*ID_BITS     per-master ARID (master i at slice i)
//   m_araddr   in   NM*ADDR_BITS   per-master ARADDR
//   m_arlen    in   NM*LEN_BITS    per-master ARLEN
//   m_arsize   in   NM*SIZE_BITS   per-master ARSIZE
//   m_arburst  in   NM*2           per-master ARBURST
//   m_arvalid  in   NM             per-master ARVALID
//   m_arready  out  NM             per-master ARREADY (at most one bit set)
//   s_arid     out  NS*IDS         {master index, ARID}, broadcast
//   s_araddr / s_arlen / s_arsize / s_arburst  out  payload, broadcast
//   s_arvalid  out  NS             one-hot or zero, qualifies the payload
//   s_arready  in   NS             per-slave ARREADY
module axi_ar_xbar #(
  parameter int NM        = 2,
  parameter int NS        = 3,
  parameter int ID_BITS   = 4,
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 4,
  parameter int SIZE_BITS = 3,
  parameter logic [(NS-1)*ADDR_BITS-1:0] SLV_BASE = {32'h0001_0000, 32'h0000_0000},
  parameter logic [(NS-1)*ADDR_BITS-1:0] SLV_MASK = {32'hFFFF_0000, 32'hFFFF_0000},
  localparam int MB  = (NM > 1) ? $clog2(NM) : 1,
  localparam int IDS = ID_BITS + MB
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NM*ID_BITS-1:0]    m_arid,
  input  logic [NM*ADDR_BITS-1:0]  m_araddr,
  input  logic [NM*LEN_BITS-1:0]   m_arlen,
  input  logic [NM*SIZE_BITS-1:0]  m_arsize,
  input  logic [NM*2-1:0]          m_arburst,
  input  logic [NM-1:0]            m_arvalid,
  output logic [NM-1:0]            m_arready,
  output logic [NS*IDS-1:0]        s_arid,
  output logic [NS*ADDR_BITS-1:0]  s_araddr,
  output logic [NS*LEN_BITS-1:0]   s_arlen,
  output logic [NS*SIZE_BITS-1:0]  s_arsize,
  output logic [NS*2-1:0]          s_arburst,
  output logic [NS-1:0]            s_arvalid,
  input  logic [NS-1:0]            s_arready
);

  localparam int TB = $clog2(NS);

  // Output slice
  logic                 valid_reg;
  logic [TB-1:0]        tgt_reg;
  logic [IDS-1:0]       id_reg;
  logic [ADDR_BITS-1:0] addr_reg;
  logic [LEN_BITS-1:0]  len_reg;
  logic [SIZE_BITS-1:0] size_reg;
  logic [1:0]           burst_reg;

  logic [MB-1:0]        win;
  logic                 any_valid;
  logic                 can_accept;
  logic                 grant;
  logic [ADDR_BITS-1:0] win_addr;
  logic [TB-1:0]        dec_tgt;

  assign any_valid  = |m_arvalid;
  // The slice can take a new request when empty or when it drains this cycle.
  assign can_accept = ~valid_reg | s_arready[tgt_reg];
  // Gating by rst keeps ARREADY low throughout reset.
  assign grant      = rst & can_accept & any_valid;

`ifdef AXI_AR_XBAR_FIXED_PRIO_EN
  // Downward scan leaves the lowest valid index as the winner.
  always_comb begin
    win = '0;
    for (int k = NM - 1; k >= 0; k--) begin
      if (m_arvalid[k]) win = MB'(k);
    end
  end
`else
  logic [MB-1:0] rr_reg;
  logic [MB-1:0] rr_next;
  int            idx;
  logic          found;

  // Search from rr upward, wrapping modulo NM; the first valid master wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NM; k++) begin
      idx = int'(rr_reg) + k;
      if (idx >= NM) idx = idx - NM;
      if (!found && m_arvalid[idx]) begin
        found = 1'b1;
        win   = MB'(idx);
      end
    end
    rr_next = (int'(win) == NM - 1) ? '0 : win + MB'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rr_reg <= '0;
    else if (grant) rr_reg <= rr_next;
  end
`endif

  assign win_addr = m_araddr[win*ADDR_BITS +: ADDR_BITS];

  // Address decode: the lowest matching region wins; no match -> default slave.
  always_comb begin
    dec_tgt = TB'(NS - 1);
    for (int s = NS - 2; s >= 0; s--) begin
      if ((win_addr & SLV_MASK[s*ADDR_BITS +: ADDR_BITS]) ==
          (SLV_BASE[s*ADDR_BITS +: ADDR_BITS] & SLV_MASK[s*ADDR_BITS +: ADDR_BITS]))
        dec_tgt = TB'(s);
    end
  end

  always_comb begin
    m_arready = '0;
    if (grant) m_arready[win] = 1'b1;
  end

  // A grant reloads the slice even when it drains on the same edge, so
  // back-to-back requests flow without bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= 1'b0;
      tgt_reg   <= '0;
      id_reg    <= '0;
      addr_reg  <= '0;
      len_reg   <= '0;
      size_reg  <= '0;
      burst_reg <= '0;
    end else if (grant) begin
      valid_reg <= 1'b1;
      tgt_reg   <= dec_tgt;
      id_reg    <= {win, m_arid[win*ID_BITS +: ID_BITS]};
      addr_reg  <= win_addr;
      len_reg   <= m_arlen[win*LEN_BITS +: LEN_BITS];
      size_reg  <= m_arsize[win*SIZE_BITS +: SIZE_BITS];
      burst_reg <= m_arburst[win*2 +: 2];
    end else if (valid_reg && s_arready[tgt_reg]) begin
      valid_reg <= 1'b0;
    end
  end

  always_comb begin
    s_arvalid = '0;
    if (valid_reg) s_arvalid[tgt_reg] = 1'b1;
  end

  // Payload is broadcast; only s_arvalid selects the slave.
  for (genvar gi = 0; gi < NS; gi++) begin : g_bcast
    assign s_arid[gi*IDS +: IDS]                = id_reg;
    assign s_araddr[gi*ADDR_BITS +: ADDR_BITS]  = addr_reg;
    assign s_arlen[gi*LEN_BITS +: LEN_BITS]     = len_reg;
    assign s_arsize[gi*SIZE_BITS +: SIZE_BITS]  = size_reg;
    assign s_arburst[gi*2 +: 2]                 = burst_reg;
  end

endmodule

// File: tb/tb_axi_ar_xbar.sv
// Self-checking bench for axi_ar_xbar (NM=2, NS=3, default address map).
module tb_axi_ar_xbar;

  localparam int NM = 2, NS = 3, IDW = 4, AW = 32, LW = 4, SW = 3, IDS = 5;
`ifdef AXI_AR_XBAR_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NM*IDW-1:0] m_arid;
  logic [NM*AW-1:0]  m_araddr;
  logic [NM*LW-1:0]  m_arlen;
  logic [NM*SW-1:0]  m_arsize;
  logic [NM*2-1:0]   m_arburst;
  logic [NM-1:0]     m_arvalid;
  logic [NM-1:0]     m_arready;
  logic [NS*IDS-1:0] s_arid;
  logic [NS*AW-1:0]  s_araddr;
  logic [NS*LW-1:0]  s_arlen;
  logic [NS*SW-1:0]  s_arsize;
  logic [NS*2-1:0]   s_arburst;
  logic [NS-1:0]     s_arvalid;
  logic [NS-1:0]     s_arready;

  axi_ar_xbar #(.NM(NM), .NS(NS), .ID_BITS(IDW), .ADDR_BITS(AW),
                .LEN_BITS(LW), .SIZE_BITS(SW)) dut (
    .clk(clk), .rst(rst),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tgt;
    logic [4:0] id;
    logic [31:0] addr;
    logic [3:0] len;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic set_m(input int m, input logic [3:0] id, input logic [31:0] addr,
                       input logic [3:0] len);
    m_arid[m*IDW +: IDW]  = id;
    m_araddr[m*AW +: AW]  = addr;
    m_arlen[m*LW +: LW]   = len;
  endtask

  task automatic push_exp(input int tgt, input logic [4:0] id, input logic [31:0] addr,
                          input logic [3:0] len);
    exp_t e;
    e.tgt = tgt; e.id = id; e.addr = addr; e.len = len;
    exp_q.push_back(e);
  endtask

  // Monitor: every slave handshake pops the next expected request.
  logic [2:0]  mon_vec;
  logic [4:0]  mon_id;
  logic [31:0] mon_addr;
  logic [3:0]  mon_len;
  always @(negedge clk) begin
    if (rst === 1'b1 && (s_arvalid & s_arready) != '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_hs: s_arvalid=%b, required no handshake", s_arvalid);
      end else begin
        mon_e    = exp_q.pop_front();
        mon_vec  = 3'b001 << mon_e.tgt;
        mon_id   = s_arid[mon_e.tgt*IDS +: IDS];
        mon_addr = s_araddr[mon_e.tgt*AW +: AW];
        mon_len  = s_arlen[mon_e.tgt*LW +: LW];
        $display("slave hs: s_arvalid=%b id=%h addr=%h len=%0d size=%0d burst=%0d",
                 s_arvalid, mon_id, mon_addr, mon_len,
                 s_arsize[mon_e.tgt*SW +: SW], s_arburst[mon_e.tgt*2 +: 2]);
        checks++;
        if (s_arvalid !== mon_vec || mon_id !== mon_e.id || mon_addr !== mon_e.addr ||
            mon_len !== mon_e.len || s_arsize[mon_e.tgt*SW +: SW] !== 3'd2 ||
            s_arburst[mon_e.tgt*2 +: 2] !== 2'b01) begin
          errors++;
          $display("FAIL slave_hs: got vld=%b id=%h addr=%h len=%0d, required vld=%b id=%h addr=%h len=%0d",
                   s_arvalid, mon_id, mon_addr, mon_len, mon_vec, mon_e.id, mon_e.addr, mon_e.len);
        end
      end
    end
  end

  int w;
  int prev_tgt;
  logic [31:0] a;

  initial begin
    rst       = 1'b0;
    s_arready = '0;
    m_arid    = '0;
    m_araddr  = '0;
    m_arlen   = '0;
    m_arsize  = {3'd2, 3'd2};
    m_arburst = {2'b01, 2'b01};
    set_m(0, 4'h1, 32'h0000_0100, 4'd1);
    set_m(1, 4'h2, 32'h0001_0200, 4'd2);
    m_arvalid = 2'b11;

    // Reset with both masters requesting
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_m_arready", 64'(m_arready), 64'(2'b00));
    chk("rst_s_arvalid", 64'(s_arvalid), 64'(3'b000));
    chk("rst_s_arid", 64'(s_arid), 64'd0);
    chk("rst_s_araddr0", 64'(s_araddr[31:0]), 64'd0);

    // Release: M0 granted in the first cycle
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("release_grant", 64'(m_arready), 64'(2'b01));
    push_exp(0, 5'h01, 32'h0000_0100, 4'd1);
    @(posedge clk); #1;

    // Backpressure on slave 0 for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_m_arready", 64'(m_arready), 64'(2'b00));
      chk("bp_s_arvalid", 64'(s_arvalid), 64'(3'b001));
      chk("bp_s_araddr0", 64'(s_araddr[31:0]), 64'h0000_0100);
      chk("bp_s_arid0", 64'(s_arid[4:0]), 64'h01);
      @(posedge clk); #1;
    end

    // Slave 0 accepts: next winner is granted in the same cycle
    s_arready = 3'b001;
    w = FIXED ? 0 : 1;
    @(negedge clk);
    chk("bp_release_grant", 64'(m_arready), 64'(2'b01 << w));
    if (w == 0) push_exp(0, 5'h01, 32'h0000_0100, 4'd1);
    else        push_exp(1, 5'h12, 32'h0001_0200, 4'd2);
    @(posedge clk); #1;
    m_arvalid = 2'b00;
    s_arready = 3'b111;
    @(negedge clk);
    chk("drain_s_arvalid", 64'(s_arvalid), 64'(3'b001 << w));
    @(posedge clk); #1;
    s_arready = 3'b000;

    // Decode into slave 1
    set_m(0, 4'h3, 32'h0001_0040, 4'd3);
    m_arvalid = 2'b01;
    @(negedge clk);
    chk("dec_grant", 64'(m_arready), 64'(2'b01));
    push_exp(1, 5'h03, 32'h0001_0040, 4'd3);
    @(posedge clk); #1;
    m_arvalid = 2'b00;
    s_arready = 3'b010;
    @(negedge clk);
    chk("dec_s_arvalid", 64'(s_arvalid), 64'(3'b010));
    chk("dec_s_arid1", 64'(s_arid[9:5]), 64'h03);
    chk("dec_s_araddr1", 64'(s_araddr[63:32]), 64'h0001_0040);
    @(posedge clk); #1;
    s_arready = 3'b000;

    // Unmapped address goes to the default slave
    set_m(1, 4'hA, 32'h2000_0000, 4'd4);
    m_arvalid = 2'b10;
    @(negedge clk);
    chk("def_grant", 64'(m_arready), 64'(2'b10));
    push_exp(2, 5'h1A, 32'h2000_0000, 4'd4);
    @(posedge clk); #1;
    m_arvalid = 2'b00;
    s_arready = 3'b100;
    @(negedge clk);
    chk("def_s_arvalid", 64'(s_arvalid), 64'(3'b100));
    chk("def_s_arid2", 64'(s_arid[14:10]), 64'h1A);
    @(posedge clk); #1;

    // Both masters streaming with all slaves ready: no bubbles
    s_arready = 3'b111;
    m_arvalid = 2'b11;
    prev_tgt  = 0;
    for (int k = 0; k < 4; k++) begin
      set_m(0, 4'h4, 32'h0000_0010 + 32'(k*16), 4'(k));
      set_m(1, 4'h5, 32'h0001_0020 + 32'(k*16), 4'(k + 8));
      w = FIXED ? 0 : (k % 2);
      @(negedge clk);
      chk("rr_grant", 64'(m_arready), 64'(2'b01 << w));
      if (k > 0) chk("rr_no_bubble", 64'(s_arvalid), 64'(3'b001 << prev_tgt));
      a = (w == 0) ? 32'h0000_0010 + 32'(k*16) : 32'h0001_0020 + 32'(k*16);
      if (w == 0) push_exp(0, 5'h04, a, 4'(k));
      else        push_exp(1, 5'h15, a, 4'(k + 8));
      prev_tgt = w;
      @(posedge clk); #1;
    end
    m_arvalid = 2'b00;
    @(negedge clk);
    chk("rr_last_s_arvalid", 64'(s_arvalid), 64'(3'b001 << prev_tgt));
    @(posedge clk); #1;

    // Mid-transfer reset drops the buffered request
    s_arready = 3'b000;
    set_m(0, 4'h6, 32'h0000_0300, 4'd5);
    m_arvalid = 2'b01;
    @(negedge clk);
    chk("mrst_grant", 64'(m_arready), 64'(2'b01));
    @(posedge clk); #1;
    @(negedge clk);
    chk("mrst_pre_s_arvalid", 64'(s_arvalid), 64'(3'b001));
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_s_arvalid", 64'(s_arvalid), 64'(3'b000));
    chk("mrst_m_arready", 64'(m_arready), 64'(2'b00));
    s_arready = 3'b111;
    m_arvalid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_after_s_arvalid", 64'(s_arvalid), 64'(3'b000));
    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_ar_xbar.md
# axi_ar_xbar

Parametrised AXI read-address (AR) crossbar between NM masters and NS slaves. The last slave index is the default (decode-error) slave. Each cycle it round-robin arbitrates among requesting masters and decodes the winner's ARADDR against a base/mask map. It registers the request in a one-entry output slice and presents it to exactly one slave, with the master index prepended to ARID. Replaces the fixed two-master/three-slave AR path in the AXI interconnect and adds full back-to-back throughput.

## Interface
- NM, 2, number of masters (≥1); MB = max(1, clog2(NM))
- NS, 3, number of slaves including default slave NS-1 (≥2)
- ID_BITS, 4, master ARID width; slave ARID width IDS = ID_BITS+MB
- ADDR_BITS, 32, address width
- LEN_BITS, 4, ARLEN width
- SIZE_BITS, 3, ARSIZE width
- SLV_BASE, {32'h0001_0000, 32'h0000_0000}, flat (NS-1)*ADDR_BITS; region base of slave s at slice s
- SLV_MASK, {32'hFFFF_0000, 32'hFFFF_0000}, flat (NS-1)*ADDR_BITS; compare mask per region

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- m_arid  in  NM*ID_BITS  per-master ARID, master i at slice i
- m_araddr  in  NM*ADDR_BITS  per-master ARADDR
- m_arlen  in  NM*LEN_BITS  per-master ARLEN
- m_arsize  in  NM*SIZE_BITS  per-master ARSIZE
- m_arburst  in  NM*2  per-master ARBURST
- m_arvalid  in  NM  per-master ARVALID
- m_arready  out  NM  per-master ARREADY
- s_arid  out  NS*IDS  per-slave ARID = {master index, ARID}
- s_araddr / s_arlen / s_arsize / s_arburst  out  NS*ADDR_BITS / NS*LEN_BITS / NS*SIZE_BITS / NS*2  payload, identical on all slices
- s_arvalid  out  NS  one-hot or zero
- s_arready  in  NS  per-slave ARREADY

## Operation
- Output slice holds: valid bit, target index tgt, payload, extended ID.
- can_accept = ~slice_valid | s_arready[tgt].
- Arbitration, round-robin (default):
  - Search m_arvalid starting at pointer rr, wrapping modulo NM; first set bit wins (w).
  - Only one master is granted per cycle.
- Grant:
  - m_arready[w] = can_accept & (any m_arvalid); this is combinational, and all other bits are 0.
  - On the master handshake, the slice loads the winner's payload, ID = {w, m_arid[w]}, tgt = decode(m_araddr[w]), and valid = 1.
  - On the same edge, rr ← (w+1) mod NM.
- Decode: the lowest s < NS-1 with (addr & SLV_MASK[s]) == (SLV_BASE[s] & SLV_MASK[s]) wins. No match → tgt = NS-1.
- s_arvalid[tgt] = slice_valid. Payload is broadcast to all slaves, and only s_arvalid qualifies it.
- Slave handshake (slice_valid & s_arready[tgt]) with no new grant → slice_valid ← 0.
- Simultaneous slave handshake and new master grant → the slice reloads; s_arvalid stays high, possibly to a different slave.
- Slice payload is stable while s_arvalid is high and s_arready is low (AXI rule).
- s_arready on non-target slaves is ignored.
- NM = 1: rr is constant 0, and the ID prefix is 1'b0.

## Timing
- Master-to-slave latency is 1 cycle: a grant at edge N makes s_arvalid high after edge N.
- Throughput is one request per cycle while the target slaves hold s_arready high.
- Reset (rst = 0, asynchronous):
  - slice_valid = 0, so s_arvalid = 0.
  - Payload, ID and tgt registers = 0.
  - rr = 0.
  - m_arready = 0 (gated by rst).
- Reset mid-transfer drops the buffered request. No handshake is reported for it.
- After rst deasserts, the first grant can occur in the first cycle.

## Configuration
- AXI_AR_XBAR_FIXED_PRIO_EN defined:
  - Fixed priority; the lowest-index valid master always wins.
  - The rr register is not built; the ID prefix is unchanged.
- Undefined (default): round-robin as in Operation.

## Test plan
- Reset:
  - rst low with all m_arvalid = 1 → m_arready = 0, s_arvalid = 0.
  - First edge after release → m_arready = 2'b01, rr = 1.
- Decode (NM = 2, NS = 3): m_arvalid = 2'b01, m_araddr[0] = 0x0001_0040, m_arid[0] = 4'h3 → next cycle s_arvalid = 3'b010, s_arid[1] = 5'h03, s_araddr[1] = 0x0001_0040.
- Default slave: m_arvalid = 2'b10, addr 0x2000_0000, id 4'hA → s_arvalid = 3'b100, s_arid[2] = 5'h1A.
- Round-robin: both masters hold valid and s_arready = 3'b111 → grants alternate M0, M1, M0, M1 on consecutive cycles with no bubbles.
  - Under AXI_AR_XBAR_FIXED_PRIO_EN, M0 is granted every cycle.
- Backpressure:
  - s_arready[0] = 0 for 5 cycles → s_arvalid[0] and payload held stable, m_arready = 0.
  - Cycle s_arready[0] = 1 → m_arready pulses for the next winner in that same cycle.
- Mid-transfer reset: rst pulsed low while s_arvalid = 3'b001 → s_arvalid = 0 immediately, no slave handshake recorded.
